// File: rtl/act_pkg.sv
// -----------------------------------------------------------------------------
// act_pkg
// Shared definitions for the multi-lane activation pipeline (act_pipe) and its
// per-lane datapath (act_lane).
//   act_mode_e     : runtime activation select carried with every beat
//   ACT_MODES      : number of activation modes
//   ACT_*_DEF      : default lane count and widths used by the modules
// -----------------------------------------------------------------------------
package act_pkg;

    typedef enum logic [1:0] {
        RELU = 2'd0,
        CLIP = 2'd1,
        HSIG = 2'd2,
        SAT  = 2'd3
    } act_mode_e;

    localparam int ACT_MODES     = 4;
    localparam int ACT_CH_DEF    = 4;
    localparam int ACT_IWID_DEF  = 14;
    localparam int ACT_OWID_DEF  = 10;
    localparam int ACT_SHIFT_DEF = 2;
    localparam int ACT_CWID_DEF  = 16;

endpackage

// File: rtl/act_lane.sv
// -----------------------------------------------------------------------------
// act_lane
// Purely combinational single-lane clamp stage. The lane value arrives already
// arithmetically shifted (x >>> SHIFT, width IWID-SHIFT); this block applies the
// selected activation and saturation.
// Ports:
//   i_s      in  IWID-SHIFT  shifted lane value, signed
//   i_mode   in  2           activation mode (act_mode_e)
//   i_cap    in  OWID        clip ceiling for CLIP mode, unsigned
//   o_y      out OWID        activated value (unsigned for RELU/CLIP/HSIG,
//                            two's complement for SAT)
//   o_upper  out 1           lane was clamped at its upper bound (SAT: either)
// -----------------------------------------------------------------------------
module act_lane
    import act_pkg::*;
#(
    parameter int IWID  = ACT_IWID_DEF,
    parameter int OWID  = ACT_OWID_DEF,
    parameter int SHIFT = ACT_SHIFT_DEF
) (
    input  logic [IWID-SHIFT-1:0]          i_s,
    input  logic [$clog2(ACT_MODES)-1:0]   i_mode,
    input  logic [OWID-1:0]                i_cap,
    output logic [OWID-1:0]                o_y,
    output logic                           o_upper
);

    localparam int SW = IWID - SHIFT;
    // Working width: wide enough for the shifted value, the output range and
    // the HSIG offset addition, so no comparison or sum can wrap.
    localparam int CW = ((SW > OWID) ? SW : OWID) + 2;

    localparam logic signed [CW-1:0] L_UMAX = CW'((2 ** OWID) - 1);
    localparam logic signed [CW-1:0] L_HALF = CW'(2 ** (OWID - 1));
    localparam logic signed [CW-1:0] L_SMAX = L_HALF - CW'(1);
    localparam logic signed [CW-1:0] L_SMIN = -L_HALF;

    logic signed [CW-1:0] w_s;
    logic signed [CW-1:0] w_h;
    logic signed [CW-1:0] w_cap;

    assign w_s   = CW'($signed(i_s));
    assign w_h   = w_s + L_HALF;
    assign w_cap = $signed({{(CW-OWID){1'b0}}, i_cap});

    always_comb begin
        o_y     = '0;
        o_upper = 1'b0;
        case (act_mode_e'(i_mode))
            RELU: begin
                if (w_s > L_UMAX) begin
                    o_y     = L_UMAX[OWID-1:0];
                    o_upper = 1'b1;
                end else if (w_s[CW-1]) begin
                    o_y = '0;
                end else begin
                    o_y = w_s[OWID-1:0];
                end
            end
            CLIP: begin
                // A zero ceiling makes every positive value an upper clamp to 0.
                if (w_s > w_cap) begin
                    o_y     = i_cap;
                    o_upper = 1'b1;
                end else if (w_s[CW-1]) begin
                    o_y = '0;
                end else begin
                    o_y = w_s[OWID-1:0];
                end
            end
            HSIG: begin
                if (w_h > L_UMAX) begin
                    o_y     = L_UMAX[OWID-1:0];
                    o_upper = 1'b1;
                end else if (w_h[CW-1]) begin
                    o_y = '0;
                end else begin
                    o_y = w_h[OWID-1:0];
                end
            end
            SAT: begin
                // Symmetric saturation: both rails count as a clamp event.
                if (w_s > L_SMAX) begin
                    o_y     = L_SMAX[OWID-1:0];
                    o_upper = 1'b1;
                end else if (w_s < L_SMIN) begin
                    o_y     = L_SMIN[OWID-1:0];
                    o_upper = 1'b1;
                end else begin
                    o_y = w_s[OWID-1:0];
                end
            end
            default: begin
                o_y     = '0;
                o_upper = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/act_pipe.sv
// -----------------------------------------------------------------------------
// act_pipe
// CH-lane, two-stage activation pipeline with valid/ready back-pressure.
//   S1 registers the shifted lanes together with the beat's mode and cap.
//   S2 registers the clamped lanes (CH act_lane instances between S1 and S2).
// Latency is two cycles; throughput one beat per cycle while out_ready is high.
// Optional build macro ACT_SAT_CNT_EN adds a saturating clamp-event counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     in   beat valid            in_ready  out  beat can be accepted
//   in_data      in   CH*IWID lanes, lane 0 in LSBs
//   in_mode      in   activation mode, travels with the beat
//   in_cap       in   CLIP ceiling, travels with the beat
//   out_valid    out  output beat valid     out_ready in   downstream accepts
//   out_data     out  CH*OWID activated lanes, lane 0 in LSBs
//   sat_cnt      out  clamp-event counter (0 unless ACT_SAT_CNT_EN)
//   sat_clr      in   synchronous counter clear (ignored unless ACT_SAT_CNT_EN)
// -----------------------------------------------------------------------------
module act_pipe
    import act_pkg::*;
#(
    parameter int CH    = ACT_CH_DEF,
    parameter int IWID  = ACT_IWID_DEF,
    parameter int OWID  = ACT_OWID_DEF,
    parameter int SHIFT = ACT_SHIFT_DEF,
    parameter int CWID  = ACT_CWID_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*IWID-1:0]   in_data,
    input  logic [1:0]           in_mode,
    input  logic [OWID-1:0]      in_cap,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*OWID-1:0]   out_data,
    output logic [CWID-1:0]      sat_cnt,
    input  logic                 sat_clr
);

    localparam int SW = IWID - SHIFT;

    logic                r_s1_valid;
    logic [CH*SW-1:0]    r_s1_s;
    logic [1:0]          r_s1_mode;
    logic [OWID-1:0]     r_s1_cap;

    logic                r_s2_valid;
    logic [CH*OWID-1:0]  r_s2_y;

    logic                w_s2_adv;
    logic                w_in_fire;
    logic [CH*SW-1:0]    w_s_all;
    logic [CH*OWID-1:0]  w_y_all;
    logic [CH-1:0]       w_upper;

    // The shifted-out LSBs never reach the datapath.
    logic [CH*IWID-1:0]  w_unused_in;
    assign w_unused_in = in_data;

    assign w_s2_adv  = !r_s2_valid | out_ready;
    assign in_ready  = !r_s1_valid | w_s2_adv;
    assign w_in_fire = in_valid & in_ready;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_y;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            // x >>> SHIFT truncated to IWID-SHIFT bits is exactly the top bits of x.
            assign w_s_all[gi*SW +: SW] = in_data[gi*IWID + SHIFT +: SW];

            act_lane #(
                .IWID  (IWID),
                .OWID  (OWID),
                .SHIFT (SHIFT)
            ) u_lane (
                .i_s     (r_s1_s[gi*SW +: SW]),
                .i_mode  (r_s1_mode),
                .i_cap   (r_s1_cap),
                .o_y     (w_y_all[gi*OWID +: OWID]),
                .o_upper (w_upper[gi])
            );
        end
    endgenerate

    // Stage 1: loads whenever it is empty or its content moves into S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_s     <= '0;
            r_s1_mode  <= '0;
            r_s1_cap   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_s    <= w_s_all;
                r_s1_mode <= in_mode;
                r_s1_cap  <= in_cap;
            end
        end
    end

    // Stage 2: holds its beat until the downstream handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y <= w_y_all;
            end
        end
    end

`ifdef ACT_SAT_CNT_EN
    localparam int PW   = $clog2(CH + 1);
    localparam int SUMW = ((CWID > PW) ? CWID : PW) + 1;
    localparam logic [SUMW-1:0] L_CMAX = SUMW'({CWID{1'b1}});

    logic [CH-1:0]    r_s2_upper;
    logic [CWID-1:0]  r_sat_cnt;
    logic [SUMW-1:0]  w_pop;
    logic [SUMW-1:0]  w_sum;

    // Clamp flags ride alongside the S2 data so they are counted only when
    // that beat actually leaves the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_upper <= '0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_s2_upper <= w_upper;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CH; i++) begin
            w_pop = w_pop + SUMW'(r_s2_upper[i]);
        end
    end

    assign w_sum = SUMW'(r_sat_cnt) + w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_sat_cnt <= (w_sum > L_CMAX) ? '1 : w_sum[CWID-1:0];
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^{sat_clr, w_upper};
    assign sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_act_pipe.sv
// -----------------------------------------------------------------------------
// tb_act_pipe
// Directed testbench for act_pipe (CH=4, IWID=14, OWID=10, SHIFT=2, CWID=4).
// Counter expectations depend on whether ACT_SAT_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_act_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [55:0] in_data;
    logic [1:0]  in_mode;
    logic [9:0]  in_cap;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
    logic [3:0]  sat_cnt;
    logic        sat_clr;

    int n_vec;
    int n_err;
    int exp_cnt;

`ifdef ACT_SAT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    act_pipe #(
        .CH    (4),
        .IWID  (14),
        .OWID  (10),
        .SHIFT (2),
        .CWID  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_cap    (in_cap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [55:0] pk(input int a, input int b, input int c, input int d);
        return {d[13:0], c[13:0], b[13:0], a[13:0]};
    endfunction

    function automatic logic [39:0] ok(input int a, input int b, input int c, input int d);
        return {d[9:0], c[9:0], b[9:0], a[9:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: present, check 2-cycle latency, check data, drain.
    task automatic beat(input string tag, input logic [1:0] m, input logic [9:0] cap,
                        input logic [55:0] d, input logic [39:0] exp, input int inc);
        in_valid = 1'b1;
        in_mode  = m;
        in_cap   = cap;
        in_data  = d;
        tick();
        // Scramble inputs so S1 must hold the sampled mode/cap/data.
        in_valid = 1'b0;
        in_mode  = m ^ 2'b11;
        in_cap   = ~cap;
        in_data  = ~d;
        chk({tag, "_lat"}, 64'(out_valid), 64'(0));
        tick();
        chk({tag, "_v"}, 64'(out_valid), 64'(1));
        chk({tag, "_d"}, 64'(out_data), 64'(exp));
        $display("beat %s mode=%0d out=%h", tag, m, out_data);
        tick();
        chk({tag, "_drain"}, 64'(out_valid), 64'(0));
        exp_cnt += inc;
        chk({tag, "_cnt"}, 64'(sat_cnt), CNT_ON ? 64'(exp_cnt) : 64'(0));
    endtask

    logic [55:0] bp_dat  [6];
    logic [1:0]  bp_mode [6];
    logic [39:0] bp_exp  [6];
    int          sent;
    int          got;
    logic        acc;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        in_cap    = '0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        chk("rst_ovalid", 64'(out_valid), 64'(0));
        chk("rst_odata", 64'(out_data), 64'(0));
        chk("rst_cnt", 64'(sat_cnt), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_irdy", 64'(in_ready), 64'(1));

        // ---------------- directed activation vectors ----------------
        beat("relu",    2'd0, 10'd0,   pk(400, -8, 8000, 0),       ok(100, 0, 1023, 0),    1);
        beat("clip255", 2'd1, 10'd255, pk(2000, 1020, -1, 4),      ok(255, 255, 0, 1),     1);
        beat("clip0",   2'd1, 10'd0,   pk(4, 0, -4, 8000),         ok(0, 0, 0, 0),         2);
        beat("hsig",    2'd2, 10'd0,   pk(0, -4000, 4000, -2048),  ok(512, 0, 1023, 0),    1);
        beat("sat",     2'd3, 10'd0,   pk(-4000, 4000, -4, 2044),  ok(-512, 511, -1, 511), 2);

        // ---------------- back-pressure stream ----------------
        // Lane 0 = -400 (s=-100) separates RELU (0) from SAT (-100);
        // lane 1 = 40*(k+1) (s=10*(k+1)) tags the beat order.
        for (int k = 0; k < 6; k++) begin
            bp_mode[k] = (k % 2 == 1) ? 2'd3 : 2'd0;
            bp_dat[k]  = pk(-400, 40 * (k + 1), 0, 0);
            bp_exp[k]  = ok((k % 2 == 1) ? -100 : 0, 10 * (k + 1), 0, 0);
        end
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            if (sent < 6) begin
                in_valid = 1'b1;
                in_mode  = bp_mode[sent];
                in_data  = bp_dat[sent];
                in_cap   = 10'd0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_irdy", 64'(in_ready), (c >= 3 && c <= 7) ? 64'(0) : 64'(1));
            if (c >= 3 && c <= 7) begin
                chk("bp_stall_v", 64'(out_valid), 64'(1));
            end
            acc = in_valid & in_ready;
            if (out_valid) begin
                if (got < 6) begin
                    chk("bp_data", 64'(out_data), 64'(bp_exp[got]));
                    if (out_ready) begin
                        $display("beat bp%0d out=%h", got, out_data);
                        got++;
                    end
                end else begin
                    chk("bp_extra", 64'(out_valid), 64'(0));
                end
            end
            tick();
            if (acc) sent++;
        end
        chk("bp_count", 64'(got), 64'(6));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_empty", 64'(out_valid), 64'(0));

        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        exp_cnt = 0;
        chk("clr_idle", 64'(sat_cnt), 64'(0));

        // ---------------- asynchronous reset with beats in flight ----------------
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_data  = pk(40, 0, 0, 0);
        tick();
        in_data  = pk(80, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("mid_pre_v", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 64'(out_valid), 64'(0));
        chk("mid_rst_d", 64'(out_data), 64'(0));
        tick();
        rst_n = 1'b1;
        beat("post_rst", 2'd0, 10'd0, pk(0, 0, 0, 400), ok(0, 0, 0, 100), 0);

        // ---------------- counter saturation and clear priority ----------------
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_data  = pk(8000, 8000, 8000, 8000);
        repeat (20) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        $display("beat cnt_stick cnt=%0d", sat_cnt);
        chk("cnt_stick", 64'(sat_cnt), CNT_ON ? 64'(15) : 64'(0));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_hs_v", 64'(out_valid), 64'(1));
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_wins", 64'(sat_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
